uart_rx: RTL and testbench

UART receiver: the receive half of the AXI4-Lite UART, companion to the transmitter.
- Samples the asynchronous serial input against a 16x oversampling strobe from the shared baud generator.
- Deframes 5–8 data bits with optional parity and 1–2 stop bits.
- Pushes good characters into an RX FIFO read by the register block.
- Raises sticky parity, framing and overrun errors, plus a programmable FIFO-level threshold flag.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo_with_clear.sv | 77 +++++++
 rtl/uart_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_state_t       : receiver deframer state encoding
//   OVERSAMPLE       : baud strobes per bit period
//   MID_SAMPLE       : strobe index of the start-bit centre
//   decode_threshold : 3-bit FIFO level code -> character count (also used by TX)
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP0  = 3'd4,
      RX_STOP1  = 3'd5
   } rx_state_t;

   // 0 -> 1 character, otherwise twice the code (2, 4, ... 14)
   function automatic logic [4:0] decode_threshold(input logic [2:0] code);
      logic [4:0] lvl;
      if (code == 3'd0) lvl = 5'd1;
      else              lvl = {1'b0, code, 1'b0};
      return lvl;
   endfunction

endpackage

// File: rtl/sync_fifo_with_clear.sv
// Synchronous FIFO with a flush input and registered read data.
//   clk, rst_n   : clock, synchronous active-low reset
//   clear_i      : flush pointers and occupancy; wins over push and pop
//   wr_en_i      : push wr_data_i (ignored when full)
//   rd_en_i      : pop (ignored when empty); rd_data_o updates the next cycle
//   full_o       : occupancy == DEPTH
//   empty_o      : occupancy == 0
//   count_o      : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_with_clear #(
   parameter int DATA_WIDTH            = 8,
   parameter int DEPTH                 = 16,
   parameter bit EXTRA_OUTPUT_REGISTER = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_i,
   input  logic                    wr_en_i,
   input  logic [DATA_WIDTH-1:0]   wr_data_i,
   input  logic                    rd_en_i,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q;
   logic [AW-1:0]         rd_ptr_q;
   logic [AW:0]           count_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  push;
   logic                  pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign push    = wr_en_i && !full_o && !clear_i;
   assign pop     = rd_en_i && !empty_o && !clear_i;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // read data survives a flush; it only changes on a real pop
   always_ff @(posedge clk) begin
      if (!rst_n)   rd_data_q <= '0;
      else if (pop) rd_data_q <= mem_q[rd_ptr_q];
   end

   if (EXTRA_OUTPUT_REGISTER) begin : g_extra_reg
      logic [DATA_WIDTH-1:0] rd_data_x_q;
      always_ff @(posedge clk) begin
         if (!rst_n) rd_data_x_q <= '0;
         else        rd_data_x_q <= rd_data_q;
      end
      assign rd_data_o = rd_data_x_q;
   end else begin : g_direct
      assign rd_data_o = rd_data_q;
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, 5-8 data bits, optional parity,
// 1-2 stop bits, RX FIFO, sticky errors and FIFO level flag.
//   clk, rst_n          : clock, synchronous active-low reset
//   i_parity            : parity seed (0 even, 1 odd)
//   i_data_bits         : data bits minus 5
//   i_stop_bits         : 0 one stop bit, 1 two
//   i_use_parity        : parity bit present
//   i_threshold_value   : FIFO level code for o_threshold
//   o_threshold         : registered, occupancy >= decoded level
//   i_fifo_rd_en        : pop; o_fifo_rd_data valid next cycle
//   i_fifo_clear        : flush FIFO
//   o_fifo_full/empty   : FIFO status
//   i_error_clear       : clear sticky errors (a same-cycle set wins)
//   o_parity_error, o_frame_error, o_overrun_error : sticky errors
//   i_rx_strb           : 16x bit-rate strobe
//   o_rx_strb_en        : baud generator run request, low in IDLE
//   i_uart_rx           : asynchronous serial input
//
// state     | meaning
// ----------+------------------------------------------------------
// RX_IDLE   | line idle, waiting for a low level on the synced input
// RX_START  | confirming the start bit at its centre
// RX_DATA   | sampling data bits LSB first, one per 16 strobes
// RX_PARITY | sampling and checking the parity bit
// RX_STOP0  | sampling the first stop bit; completes 1-stop frames
// RX_STOP1  | sampling the second stop bit; completes the frame
module uart_rx #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_parity,
   input  logic [1:0] i_data_bits,
   input  logic       i_stop_bits,
   input  logic       i_use_parity,
   input  logic [2:0] i_threshold_value,
   output logic       o_threshold,
   input  logic       i_fifo_rd_en,
   output logic [7:0] o_fifo_rd_data,
   input  logic       i_fifo_clear,
   output logic       o_fifo_full,
   output logic       o_fifo_empty,
   input  logic       i_error_clear,
   output logic       o_parity_error,
   output logic       o_frame_error,
   output logic       o_overrun_error,
   input  logic       i_rx_strb,
   output logic       o_rx_strb_en,
   input  logic       i_uart_rx
);

   import uart_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rx_state_t  state_q, state_d;
   logic       rx_meta_q, rx_s_q;
   logic [3:0] strb_cnt_q, strb_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       calc_par_q, calc_par_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;
   logic [1:0] data_bits_q, data_bits_d;
   logic       stop_bits_q, stop_bits_d;
   logic       use_par_q, use_par_d;
   logic       frame_done;
   logic       mid_tick, bit_tick;

   logic       par_err_q, frm_err_q, ovr_err_q;
   logic       par_err_d, frm_err_d, ovr_err_d;
   logic       frame_good, fifo_push;
   logic       thr_q;
   logic [CW-1:0] fifo_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RX_IDLE;
         strb_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         calc_par_q  <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         data_bits_q <= '0;
         stop_bits_q <= 1'b0;
         use_par_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         strb_cnt_q  <= strb_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         calc_par_q  <= calc_par_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         data_bits_q <= data_bits_d;
         stop_bits_q <= stop_bits_d;
         use_par_q   <= use_par_d;
      end
   end

   assign mid_tick = i_rx_strb && (strb_cnt_q == 4'(MID_SAMPLE - 1));
   assign bit_tick = i_rx_strb && (strb_cnt_q == 4'(OVERSAMPLE - 1));

   always_comb begin
      state_d     = state_q;
      strb_cnt_d  = strb_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      calc_par_d  = calc_par_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      data_bits_d = data_bits_q;
      stop_bits_d = stop_bits_q;
      use_par_d   = use_par_q;
      frame_done  = 1'b0;

      if (state_q != RX_IDLE && i_rx_strb) strb_cnt_d = strb_cnt_q + 4'd1;

      case (state_q)
         RX_IDLE: begin
            if (!rx_s_q) begin
               data_bits_d = i_data_bits;
               stop_bits_d = i_stop_bits;
               use_par_d   = i_use_parity;
               calc_par_d  = i_parity;
               strb_cnt_d  = '0;
               bit_cnt_d   = '0;
               shift_d     = '0;
               perr_d      = 1'b0;
               ferr_d      = 1'b0;
               state_d     = RX_START;
            end
         end
         RX_START: begin
            if (mid_tick) begin
               if (rx_s_q) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d    = RX_DATA;
                  strb_cnt_d = '0;
               end
            end
         end
         RX_DATA: begin
            if (bit_tick) begin
               shift_d[bit_cnt_q] = rx_s_q;
               calc_par_d         = calc_par_q ^ rx_s_q;
               bit_cnt_d          = bit_cnt_q + 3'd1;
               if (bit_cnt_q == {1'b0, data_bits_q} + 3'd4)
                  state_d = use_par_q ? RX_PARITY : RX_STOP0;
            end
         end
         RX_PARITY: begin
            if (bit_tick) begin
               if (rx_s_q != calc_par_q) perr_d = 1'b1;
               state_d = RX_STOP0;
            end
         end
         RX_STOP0: begin
            if (bit_tick) begin
               if (!rx_s_q) ferr_d = 1'b1;
               if (stop_bits_q) begin
                  state_d = RX_STOP1;
               end else begin
                  frame_done = 1'b1;
                  state_d    = RX_IDLE;
               end
            end
         end
         RX_STOP1: begin
            if (bit_tick) begin
               if (!rx_s_q) ferr_d = 1'b1;
               frame_done = 1'b1;
               state_d    = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // ferr_d folds in the stop sample taken in this same completion cycle
   assign frame_good = frame_done && !perr_q && !ferr_d;
   assign fifo_push  = frame_good && !o_fifo_full;

   assign par_err_d = (frame_done && perr_q) || (par_err_q && !i_error_clear);
   assign frm_err_d = (frame_done && ferr_d) || (frm_err_q && !i_error_clear);
   assign ovr_err_d = (frame_good && o_fifo_full) || (ovr_err_q && !i_error_clear);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         ovr_err_q <= 1'b0;
         thr_q     <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
         frm_err_q <= frm_err_d;
         ovr_err_q <= ovr_err_d;
         thr_q     <= 32'(fifo_count) >= 32'(decode_threshold(i_threshold_value));
      end
   end

   sync_fifo_with_clear #(
      .DATA_WIDTH            (8),
      .DEPTH                 (FIFO_DEPTH),
      .EXTRA_OUTPUT_REGISTER (1'b0)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (i_fifo_clear),
      .wr_en_i   (fifo_push),
      .wr_data_i (shift_q),
      .rd_en_i   (i_fifo_rd_en),
      .rd_data_o (o_fifo_rd_data),
      .full_o    (o_fifo_full),
      .empty_o   (o_fifo_empty),
      .count_o   (fifo_count)
   );

   assign o_rx_strb_en    = (state_q != RX_IDLE);
   assign o_threshold     = thr_q;
   assign o_parity_error  = par_err_q;
   assign o_frame_error   = frm_err_q;
   assign o_overrun_error = ovr_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx. Frames are built bit by bit from
// the character format; the expected FIFO contents and sticky flags come from
// a queue-based model of the frame rules.
module tb_uart_rx;

   localparam int FIFO_DEPTH = 16;
   localparam int STRB_DIV   = 4;
   localparam int BIT_CLKS   = 16 * STRB_DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_parity = 1'b0;
   logic [1:0] i_data_bits = 2'd3;
   logic       i_stop_bits = 1'b0;
   logic       i_use_parity = 1'b0;
   logic [2:0] i_threshold_value = 3'd7;
   logic       o_threshold;
   logic       i_fifo_rd_en = 1'b0;
   logic [7:0] o_fifo_rd_data;
   logic       i_fifo_clear = 1'b0;
   logic       o_fifo_full;
   logic       o_fifo_empty;
   logic       i_error_clear = 1'b0;
   logic       o_parity_error;
   logic       o_frame_error;
   logic       o_overrun_error;
   logic       i_rx_strb = 1'b0;
   logic       o_rx_strb_en;
   logic       i_uart_rx = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   bit m_perr = 0, m_ferr = 0, m_ovr = 0;
   int lvl_tab [8] = '{1, 2, 4, 6, 8, 10, 12, 14};

   uart_rx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_parity          (i_parity),
      .i_data_bits       (i_data_bits),
      .i_stop_bits       (i_stop_bits),
      .i_use_parity      (i_use_parity),
      .i_threshold_value (i_threshold_value),
      .o_threshold       (o_threshold),
      .i_fifo_rd_en      (i_fifo_rd_en),
      .o_fifo_rd_data    (o_fifo_rd_data),
      .i_fifo_clear      (i_fifo_clear),
      .o_fifo_full       (o_fifo_full),
      .o_fifo_empty      (o_fifo_empty),
      .i_error_clear     (i_error_clear),
      .o_parity_error    (o_parity_error),
      .o_frame_error     (o_frame_error),
      .o_overrun_error   (o_overrun_error),
      .i_rx_strb         (i_rx_strb),
      .o_rx_strb_en      (o_rx_strb_en),
      .i_uart_rx         (i_uart_rx)
   );

   always #5 clk = ~clk;

   // free-running baud strobe, one pulse every STRB_DIV clocks
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         i_rx_strb = (c == 0);
         c = (c + 1) % STRB_DIV;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every accepted pop is matched against the model queue
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n && i_fifo_rd_en && !o_fifo_empty) begin
            #1;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rd_underflow: got 0x%0h, expected no character", o_fifo_rd_data);
            end else begin
               check("rd_data", 32'(o_fifo_rd_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits, input bit use_par,
                             input bit odd, input int nstop, input bit bad_par, input bit bad_stop);
      logic [7:0] ch;
      logic       pbit;
      ch   = data & 8'((1 << nbits) - 1);
      pbit = (^ch) ^ odd ^ bad_par;
      if (use_par && bad_par) m_perr = 1;
      if (bad_stop) m_ferr = 1;
      if (!(use_par && bad_par) && !bad_stop) begin
         if (exp_q.size() >= FIFO_DEPTH) m_ovr = 1;
         else exp_q.push_back(ch);
      end
      @(negedge clk);
      i_data_bits  = 2'(nbits - 5);
      i_use_parity = use_par;
      i_parity     = odd;
      i_stop_bits  = (nstop == 2);
      i_uart_rx    = 1'b0;
      tick(BIT_CLKS);
      for (int b = 0; b < nbits; b++) begin
         i_uart_rx = ch[b];
         tick(BIT_CLKS);
      end
      if (use_par) begin
         i_uart_rx = pbit;
         tick(BIT_CLKS);
      end
      for (int s = 0; s < nstop; s++) begin
         if (bad_stop && s == 0) begin
            // low only across the sample point, so the receiver's early return
            // to idle sees a line that is high again by its start-bit check
            i_uart_rx = 1'b0;
            tick(BIT_CLKS * 3 / 4);
            i_uart_rx = 1'b1;
            tick(BIT_CLKS / 4);
         end else begin
            i_uart_rx = 1'b1;
            tick(BIT_CLKS);
         end
      end
      i_uart_rx = 1'b1;
      tick(BIT_CLKS);
   endtask

   task automatic check_status(input string tag);
      tick(2);
      check({tag, "_perr"},   32'(o_parity_error),  32'(m_perr));
      check({tag, "_ferr"},   32'(o_frame_error),   32'(m_ferr));
      check({tag, "_ovr"},    32'(o_overrun_error), 32'(m_ovr));
      check({tag, "_empty"},  32'(o_fifo_empty),    32'(exp_q.size() == 0));
      check({tag, "_full"},   32'(o_fifo_full),     32'(exp_q.size() == FIFO_DEPTH));
      check({tag, "_thr"},    32'(o_threshold),     32'(exp_q.size() >= lvl_tab[i_threshold_value]));
      check({tag, "_strben"}, 32'(o_rx_strb_en),    32'd0);
   endtask

   task automatic read_one();
      check("empty_before_read", 32'(o_fifo_empty), 32'(exp_q.size() == 0));
      i_fifo_rd_en = 1'b1;
      tick(1);
      i_fifo_rd_en = 1'b0;
      tick(1);
   endtask

   task automatic clear_errors();
      i_error_clear = 1'b1;
      tick(1);
      i_error_clear = 1'b0;
      m_perr = 0;
      m_ferr = 0;
      m_ovr  = 0;
   endtask

   task automatic clear_fifo();
      i_fifo_clear = 1'b1;
      tick(1);
      i_fifo_clear = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      tick(4);
      check("rst_empty",   32'(o_fifo_empty),    32'd1);
      check("rst_full",    32'(o_fifo_full),     32'd0);
      check("rst_thr",     32'(o_threshold),     32'd0);
      check("rst_strben",  32'(o_rx_strb_en),    32'd0);
      check("rst_perr",    32'(o_parity_error),  32'd0);
      check("rst_ferr",    32'(o_frame_error),   32'd0);
      check("rst_ovr",     32'(o_overrun_error), 32'd0);
      check("rst_rd_data", 32'(o_fifo_rd_data),  32'd0);
      rst_n = 1'b1;
      tick(4);

      // 8N1 0xA5
      send_frame(8'hA5, 8, 0, 0, 1, 0, 0);
      check_status("8n1");
      read_one();

      // 7E2 good then bad parity
      send_frame(8'h35, 7, 1, 0, 2, 0, 0);
      check_status("7e2_good");
      send_frame(8'h35, 7, 1, 0, 2, 1, 0);
      check_status("7e2_bad");
      read_one();
      clear_errors();
      check_status("7e2_clr");

      // 5N1 good then stop bit low
      send_frame(8'h1F, 5, 0, 0, 1, 0, 0);
      send_frame(8'h0A, 5, 0, 0, 1, 0, 1);
      check_status("5n1");
      read_one();
      clear_errors();

      // short low glitch on an idle line
      i_uart_rx = 1'b0;
      tick(4 * STRB_DIV);
      i_uart_rx = 1'b1;
      tick(2 * BIT_CLKS);
      check_status("glitch");

      // overrun
      for (int k = 0; k < FIFO_DEPTH + 1; k++)
         send_frame(8'($urandom_range(255)), 8, 0, 0, 1, 0, 0);
      check_status("ovr_full");
      for (int k = 0; k < FIFO_DEPTH; k++) read_one();
      check_status("ovr_drained");
      clear_errors();

      // threshold at 4 characters
      i_threshold_value = 3'd2;
      for (int k = 0; k < 3; k++) send_frame(8'($urandom_range(255)), 8, 0, 0, 1, 0, 0);
      check_status("thr_3");
      send_frame(8'($urandom_range(255)), 8, 0, 0, 1, 0, 0);
      check_status("thr_4");
      read_one();
      check_status("thr_pop");
      clear_fifo();
      check_status("thr_clear");

      // reset in the middle of a frame
      @(negedge clk);
      i_data_bits  = 2'd3;
      i_use_parity = 1'b0;
      i_stop_bits  = 1'b0;
      i_uart_rx    = 1'b0;
      tick(BIT_CLKS);
      i_uart_rx = 1'b1;
      tick(2 * BIT_CLKS);
      check("busy_strben", 32'(o_rx_strb_en), 32'd1);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      exp_q.delete();
      m_perr = 0;
      m_ferr = 0;
      m_ovr  = 0;
      tick(12 * BIT_CLKS);
      check_status("rst_mid");

      // randomised frames
      for (int k = 0; k < 20; k++) begin
         int  nb, ns, nrd;
         bit  up, od, bp, bs;
         nb = 5 + int'($urandom_range(3));
         ns = 1 + int'($urandom_range(1));
         up = 1'($urandom_range(1));
         od = 1'($urandom_range(1));
         bp = ($urandom_range(4) == 0);
         bs = ($urandom_range(4) == 0);
         i_threshold_value = 3'($urandom_range(7));
         send_frame(8'($urandom_range(255)), nb, up, od, ns, bp, bs);
         check_status("rand");
         nrd = int'($urandom_range(2));
         for (int r = 0; r < nrd; r++)
            if (exp_q.size() != 0) read_one();
         if ($urandom_range(3) == 0) clear_errors();
      end
      while (exp_q.size() != 0) read_one();
      check_status("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
